// File: rtl/k_bit_pkg.sv
// k_bit_pkg: shared types and constants for the k-bit mode shifter.
// Holds the operation encoding, FSM states and default LFSR taps/seed.
package k_bit_pkg;

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_SHL  = 3'b001,
      MODE_SHR  = 3'b010,
      MODE_LOAD = 3'b011,
      MODE_ROL  = 3'b100,
      MODE_ROR  = 3'b101,
      MODE_LFSR = 3'b110,
      MODE_RSVD = 3'b111
   } mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam logic [7:0] DEF_TAPS = 8'hB8;
   localparam logic [7:0] DEF_SEED = 8'h01;

   // True for the modes that advance q once per cycle over count steps.
   function automatic logic is_step_mode(input mode_e m);
      return (m == MODE_SHL) || (m == MODE_SHR) ||
             (m == MODE_ROL) || (m == MODE_ROR) ||
             (m == MODE_LFSR);
   endfunction

endpackage

// File: rtl/k_bit_lfsr_next.sv
// k_bit_lfsr_next: one Fibonacci LFSR step, combinational.
// Ports: q (current value) -> q_next (value after one step).
module k_bit_lfsr_next
   import k_bit_pkg::*;
#(
   parameter int              WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEF_TAPS),
   parameter logic [WIDTH-1:0] SEED = WIDTH'(DEF_SEED)
) (
   input  logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_next
);

   logic fb;

   always_comb begin
      fb = ^(q & TAPS);
      // The all-zero state is a lock-up point for an XOR LFSR,
      // so a step taken from it injects the seed instead.
      if (q == '0) begin
         q_next = SEED;
      end else begin
         q_next = {q[WIDTH-2:0], fb};
      end
   end

endmodule

// File: rtl/k_bit_mode_shifter.sv
// k_bit_mode_shifter: synchronous multi-mode shift/rotate/load/LFSR register.
// Ports: clk, rst (sync, active-high), start/mode/count/par_in/ser_in in;
//        q, ser_out, busy, done out.
module k_bit_mode_shifter
   import k_bit_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter int               CNT_W = $clog2(WIDTH + 1),
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [CNT_W-1:0] count,
   input  logic [WIDTH-1:0] par_in,
   input  logic             ser_in,
   output logic [WIDTH-1:0] q,
   output logic             ser_out,
   output logic             busy,
   output logic             done
);

   state_e           state;
   state_e           state_n;
   mode_e            op;
   mode_e            op_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic [WIDTH-1:0] q_n;
   logic             so_n;
   logic             busy_n;
   logic             done_n;

   logic [WIDTH-1:0] lfsr_q;
   logic [WIDTH-1:0] step_q;
   logic             step_so;

   mode_e            mode_in;

   assign mode_in = mode_e'(mode);

   k_bit_lfsr_next #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .SEED  (SEED)
   ) u_lfsr (
      .q      (q),
      .q_next (lfsr_q)
   );

   // One step of the latched operation; only used while in RUN.
   always_comb begin
      step_q  = q;
      step_so = ser_out;
      unique case (1'b1)
         (op == MODE_SHL): begin
            step_q  = {q[WIDTH-2:0], ser_in};
            step_so = q[WIDTH-1];
         end
         (op == MODE_SHR): begin
            step_q  = {ser_in, q[WIDTH-1:1]};
            step_so = q[0];
         end
         (op == MODE_ROL): begin
            step_q  = {q[WIDTH-2:0], q[WIDTH-1]};
            step_so = q[WIDTH-1];
         end
         (op == MODE_ROR): begin
            step_q  = {q[0], q[WIDTH-1:1]};
            step_so = q[0];
         end
         (op == MODE_LFSR): begin
            step_q  = lfsr_q;
            step_so = q[WIDTH-1];
         end
         default: begin
            step_q  = q;
            step_so = ser_out;
         end
      endcase
   end

   always_comb begin
      state_n = state;
      op_n    = op;
      cnt_n   = cnt;
      q_n     = q;
      so_n    = ser_out;
      busy_n  = busy;
      done_n  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               op_n = mode_in;
               if (mode_in == MODE_LOAD) begin
                  q_n    = par_in;
                  done_n = 1'b1;
               end else if (is_step_mode(mode_in) &&
                            (count != '0)) begin
                  state_n = ST_RUN;
                  busy_n  = 1'b1;
                  cnt_n   = count;
               end else begin
                  // HOLD, reserved or zero-length: complete at once.
                  done_n = 1'b1;
               end
            end
         end
         ST_RUN: begin
            q_n   = step_q;
            so_n  = step_so;
            cnt_n = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               state_n = ST_IDLE;
               busy_n  = 1'b0;
               done_n  = 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
            busy_n  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         op      <= MODE_HOLD;
         cnt     <= '0;
         q       <= '0;
         ser_out <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         op      <= op_n;
         cnt     <= cnt_n;
         q       <= q_n;
         ser_out <= so_n;
         busy    <= busy_n;
         done    <= done_n;
      end
   end

endmodule

// File: tb/tb_k_bit_mode_shifter.sv
// tb_k_bit_mode_shifter: directed self-checking bench for k_bit_mode_shifter.
// Drives scenarios one task each and compares against hand-computed values.
module tb_k_bit_mode_shifter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [2:0] mode = 3'b000;
   logic [3:0] count = 4'd0;
   logic [7:0] par_in = 8'h00;
   logic       ser_in = 1'b0;
   logic [7:0] q;
   logic       ser_out;
   logic       busy;
   logic       done;

   int errors = 0;
   int checks = 0;

   k_bit_mode_shifter dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .mode    (mode),
      .count   (count),
      .par_in  (par_in),
      .ser_in  (ser_in),
      .q       (q),
      .ser_out (ser_out),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if (busy && done) begin
            errors++;
            $display("FAIL busy_done_excl: busy=%b done=%b want not both",
                     busy, done);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [2:0] m, input logic [3:0] c,
                         input logic [7:0] p);
      start  = 1'b1;
      mode   = m;
      count  = c;
      par_in = p;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (q !== 8'h00) begin
         errors++; $display("FAIL reset_q: got %h want 00", q);
      end
      checks++;
      if (ser_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: so=%b busy=%b done=%b want 000",
                  ser_out, busy, done);
      end
   endtask

   task automatic test_load();
      launch(3'b011, 4'd0, 8'hA5);
      checks++;
      if (q !== 8'hA5 || done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL load: q=%h done=%b busy=%b want A5 1 0",
                  q, done, busy);
      end
      tick();
      checks++;
      if (q !== 8'hA5 || done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL load_after: q=%h done=%b busy=%b want A5 0 0",
                  q, done, busy);
      end
   endtask

   task automatic test_shift_left();
      logic [7:0] eq [3];
      logic       es [3];
      eq = '{8'h4B, 8'h97, 8'h2F};
      es = '{1'b1, 1'b0, 1'b1};
      ser_in = 1'b1;
      launch(3'b001, 4'd3, 8'h00);
      checks++;
      if (q !== 8'hA5 || busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL shl_e0: q=%h busy=%b done=%b want A5 1 0",
                  q, busy, done);
      end
      for (int i = 0; i < 3; i++) begin
         mode   = 3'b011;
         par_in = 8'hFF;
         tick();
         checks++;
         if (q !== eq[i] || ser_out !== es[i]) begin
            errors++;
            $display("FAIL shl_step%0d: q=%h so=%b want %h %b",
                     i, q, ser_out, eq[i], es[i]);
         end
         checks++;
         if (busy !== (i < 2) || done !== (i == 2)) begin
            errors++;
            $display("FAIL shl_flags%0d: busy=%b done=%b want %b %b",
                     i, busy, done, (i < 2), (i == 2));
         end
      end
      tick();
      checks++;
      if (done !== 1'b0 || q !== 8'h2F) begin
         errors++;
         $display("FAIL shl_end: done=%b q=%h want 0 2F", done, q);
      end
   endtask

   task automatic test_rotate_right();
      launch(3'b101, 4'd4, 8'h00);
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (q !== 8'hF2 || ser_out !== 1'b1 || done !== 1'b1) begin
         errors++;
         $display("FAIL ror: q=%h so=%b done=%b want F2 1 1",
                  q, ser_out, done);
      end
   endtask

   task automatic test_count_zero();
      launch(3'b001, 4'd0, 8'h00);
      checks++;
      if (q !== 8'hF2 || done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL cnt0: q=%h done=%b busy=%b want F2 1 0",
                  q, done, busy);
      end
      tick();
      checks++;
      if (q !== 8'hF2 || done !== 1'b0) begin
         errors++;
         $display("FAIL cnt0_after: q=%h done=%b want F2 0", q, done);
      end
   endtask

   task automatic test_lfsr_reseed();
      logic [7:0] eq [3];
      eq = '{8'h01, 8'h02, 8'h04};
      rst = 1'b1;
      tick();
      rst = 1'b0;
      launch(3'b110, 4'd3, 8'h00);
      checks++;
      if (q !== 8'h00 || busy !== 1'b1) begin
         errors++;
         $display("FAIL lfsr_e0: q=%h busy=%b want 00 1", q, busy);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (q !== eq[i] || done !== (i == 2)) begin
            errors++;
            $display("FAIL lfsr_step%0d: q=%h done=%b want %h %b",
                     i, q, done, eq[i], (i == 2));
         end
      end
      checks++;
      if (ser_out !== 1'b0) begin
         errors++; $display("FAIL lfsr_so: got %b want 0", ser_out);
      end
   endtask

   task automatic test_ignored_start();
      int ndone;
      logic [7:0] eq [4];
      eq = '{8'h78, 8'h3C, 8'h1E, 8'h0F};
      ndone = 0;
      launch(3'b011, 4'd0, 8'hF0);
      tick();
      ser_in = 1'b0;
      launch(3'b010, 4'd4, 8'h00);
      for (int i = 0; i < 6; i++) begin
         if (i == 0) begin
            start  = 1'b1;
            mode   = 3'b011;
            par_in = 8'hFF;
         end
         tick();
         start = 1'b0;
         if (done === 1'b1) ndone++;
         if (i < 4) begin
            checks++;
            if (q !== eq[i]) begin
               errors++;
               $display("FAIL ign_step%0d: q=%h want %h", i, q, eq[i]);
            end
         end
      end
      checks++;
      if (q !== 8'h0F) begin
         errors++; $display("FAIL ign_final: q=%h want 0F", q);
      end
      checks++;
      if (ndone != 1) begin
         errors++; $display("FAIL ign_dones: got %0d want 1", ndone);
      end
   endtask

   task automatic test_reset_abort();
      ser_in = 1'b1;
      launch(3'b001, 4'd5, 8'h00);
      tick();
      tick();
      checks++;
      if (q !== 8'h3F || busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre: q=%h busy=%b want 3F 1", q, busy);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (q !== 8'h00 || busy !== 1'b0 || ser_out !== 1'b0 ||
          done !== 1'b0) begin
         errors++;
         $display("FAIL abort_rst: q=%h busy=%b so=%b done=%b want 00 000",
                  q, busy, ser_out, done);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_nodone: done=%b busy=%b want 0 0",
                  done, busy);
      end
      launch(3'b011, 4'd0, 8'h5A);
      checks++;
      if (q !== 8'h5A || done !== 1'b1) begin
         errors++;
         $display("FAIL abort_load: q=%h done=%b want 5A 1", q, done);
      end
      ser_in = 1'b0;
      launch(3'b001, 4'd1, 8'h00);
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL abort_shl_busy: got %b want 1", busy);
      end
      tick();
      checks++;
      if (q !== 8'hB4 || done !== 1'b1 || ser_out !== 1'b0) begin
         errors++;
         $display("FAIL abort_shl: q=%h done=%b so=%b want B4 1 0",
                  q, done, ser_out);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_shift_left();
      test_rotate_right();
      test_count_zero();
      test_lfsr_reseed();
      test_ignored_start();
      test_reset_abort();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
